// File: rtl/aes_chain_mode.sv
// Block-chaining wrapper around an AES round core: ECB/CBC/CTR/OFB/CFB pre- and
// post-processing, one block in flight, chaining value held across blocks.
module aes_chain_mode #(
    parameter int unsigned BLK_S    = 128,
    parameter int unsigned IV_BITS  = 128,
    parameter int unsigned CTR_BITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         mode,
    input  logic               encryption,
    input  logic               iv_load,
    input  logic [IV_BITS-1:0] iv_in,
    output logic [IV_BITS-1:0] iv_out,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLK_S-1:0]   in_blk,
    output logic               core_start,
    output logic               core_encrypt,
    output logic [BLK_S-1:0]   core_blk,
    input  logic               core_done,
    input  logic [BLK_S-1:0]   core_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLK_S-1:0]   out_blk
);

    localparam logic [2:0] MODE_ECB = 3'd0;
    localparam logic [2:0] MODE_CBC = 3'd1;
    localparam logic [2:0] MODE_CTR = 3'd2;
    localparam logic [2:0] MODE_OFB = 3'd3;
    localparam logic [2:0] MODE_CFB = 3'd4;

    typedef enum logic [1:0] {StIdle, StCore, StOut} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [IV_BITS-1:0] r_iv;
    logic [BLK_S-1:0]   r_blk;
    logic [2:0]         r_mode;
    logic               r_enc;
    logic               r_core_start;
    logic               r_core_enc;
    logic [BLK_S-1:0]   r_core_blk;
    logic [BLK_S-1:0]   r_out_blk;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_iv_load;
    logic               w_done;
    logic [BLK_S-1:0]   w_core_blk_d;
    logic               w_core_enc_d;
    logic [BLK_S-1:0]   w_xor;
    logic [IV_BITS-1:0] w_ctr_next;
    logic [BLK_S-1:0]   w_out_d;
    logic [IV_BITS-1:0] w_iv_d;

    always_comb begin
        w_in_ready = (r_state == StIdle) && !iv_load && (mode <= MODE_CFB) && !reset;
        w_accept   = in_valid && w_in_ready;
        w_iv_load  = (r_state == StIdle) && iv_load;
        // A done pulse in the start cycle belongs to no request of ours.
        w_done     = (r_state == StCore) && core_done && !r_core_start;

        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept)  w_state_next = StCore;
            StCore:  if (w_done)    w_state_next = StOut;
            StOut:   if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Core request, evaluated against the live inputs at acceptance.
    always_comb begin
        w_core_blk_d = r_iv;
        w_core_enc_d = 1'b1;
        case (mode)
            MODE_ECB: begin
                w_core_blk_d = in_blk;
                w_core_enc_d = encryption;
            end
            MODE_CBC: begin
                w_core_blk_d = encryption ? (in_blk ^ r_iv) : in_blk;
                w_core_enc_d = encryption;
            end
            default: ;
        endcase
    end

    // Post-processing, evaluated against the latched block when the core finishes.
    always_comb begin
        w_xor      = core_result ^ r_blk;
        w_ctr_next = r_iv;
        w_ctr_next[CTR_BITS-1:0] = r_iv[CTR_BITS-1:0] + CTR_BITS'(1);
        w_out_d    = core_result;
        w_iv_d     = r_iv;
        case (r_mode)
            MODE_CBC: begin
                w_out_d = r_enc ? core_result : (core_result ^ r_iv);
                w_iv_d  = r_enc ? core_result : r_blk;
            end
            MODE_CTR: begin
                w_out_d = w_xor;
                w_iv_d  = w_ctr_next;
            end
            MODE_OFB: begin
                w_out_d = w_xor;
                w_iv_d  = core_result;
            end
            MODE_CFB: begin
                w_out_d = w_xor;
                w_iv_d  = r_enc ? w_xor : r_blk;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iv         <= '0;
            r_blk        <= '0;
            r_mode       <= '0;
            r_enc        <= 1'b0;
            r_core_start <= 1'b0;
            r_core_enc   <= 1'b0;
            r_core_blk   <= '0;
            r_out_blk    <= '0;
        end else begin
            r_core_start <= w_accept;
            if (w_iv_load) begin
                r_iv <= iv_in;
            end
            if (w_accept) begin
                r_blk      <= in_blk;
                r_mode     <= mode;
                r_enc      <= encryption;
                r_core_blk <= w_core_blk_d;
                r_core_enc <= w_core_enc_d;
            end
            if (w_done) begin
                r_out_blk <= w_out_d;
                r_iv      <= w_iv_d;
            end
        end
    end

    always_comb begin
        in_ready     = w_in_ready;
        iv_out       = r_iv;
        core_start   = r_core_start;
        core_encrypt = r_core_enc;
        core_blk     = r_core_blk;
        out_valid    = (r_state == StOut);
        out_blk      = r_out_blk;
    end

endmodule

// File: doc/aes_chain_mode.md
# aes_chain_mode

Parametrised block-chaining unit between the AXI stream front end and the AES round core. It accepts one plaintext/ciphertext block per handshake and applies ECB, CBC, CTR, OFB or CFB pre-/post-processing. It issues one request to the core per block, holds the chaining value (IV/counter) in an internal register across blocks, and presents the result on a valid/ready output.

## Interface
Parameters:
- BLK_S, 128, block width in bits.
- IV_BITS, 128, chaining register width; must equal BLK_S.
- CTR_BITS, 32, width of the low counter field incremented in CTR mode (1..IV_BITS).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- mode  in  3  0=ECB, 1=CBC, 2=CTR, 3=OFB, 4=CFB; 5-7 are illegal.
- encryption  in  1  1=encrypt, 0=decrypt.
- iv_load  in  1  load iv_in into the chaining register.
- iv_in  in  IV_BITS  new IV/counter value.
- iv_out  out  IV_BITS  current chaining register.
- in_valid, in_ready  in/out  1  input block handshake.
- in_blk  in  BLK_S  input block.
- core_start  out  1  one-cycle request to the AES core.
- core_encrypt  out  1  direction for the core.
- core_blk  out  BLK_S  block to the core; stable from core_start until core_done.
- core_done  in  1  core result valid (single-cycle pulse).
- core_result  in  BLK_S  core output.
- out_valid, out_ready  out/in  1  output handshake.
- out_blk  out  BLK_S  output block.

## Operation
- FSM states:
  - IDLE: in_ready = !iv_load && legal mode.
  - CORE: waiting for core_done.
  - OUT: out_valid=1, held until out_ready.
- Transitions:
  - IDLE → CORE on in_valid && in_ready.
  - CORE → OUT on core_done.
  - OUT → IDLE on out_ready.
- Capture at acceptance: in_blk, mode and encryption are latched. Later changes to mode/encryption do not affect the block in flight.
- iv_load is honoured only in IDLE. It takes priority over acceptance (in_ready=0 that cycle). In CORE/OUT it is ignored.
- Per-mode processing (in = latched block, r = core_result, iv = chaining register):
  - ECB: core_blk=in; out=r; iv unchanged; core_encrypt=encryption.
  - CBC enc: core_blk=in^iv; out=r; iv←r.
  - CBC dec: core_blk=in; out=r^iv; iv←in; core_encrypt=encryption.
  - CTR: core_blk=iv; out=r^in. iv[CTR_BITS-1:0]←+1 mod 2^CTR_BITS; upper bits unchanged.
  - OFB: core_blk=iv; out=r^in; iv←r.
  - CFB: core_blk=iv; out=r^in; iv←(enc ? out : in).
  - CTR, OFB and CFB: core_encrypt=1 regardless of direction.
- out_blk and the iv update are both registered on the edge where core_done is sampled in CORE.
- core_done outside CORE, or during the core_start cycle, is ignored.

## Timing
- Reset values: state=IDLE, iv=0, iv_out=0, core_start=0, core_blk=0, core_encrypt=0, out_valid=0, out_blk=0, in_ready=0 during reset.
- Request timing: acceptance at edge E0. core_start=1 for exactly the cycle after E0; core_blk is valid in that same cycle.
- Latency: if core_done is high N≥1 cycles after core_start, out_valid rises at the edge ending that core_done cycle. Minimum latency from acceptance to out_valid is N+1 cycles.
- Throughput: one block in flight; no new acceptance before the OUT→IDLE edge. in_ready rises in the first IDLE cycle.
- out_blk and out_valid hold stable while out_ready=0.
- Reset mid-operation: block discarded, iv cleared. A late core_done is ignored.
- CTR wrap: counter all-ones → all zeros, with no carry into bits ≥CTR_BITS.
- Illegal mode (5-7): in_ready=0, no state change.

## Test plan
Bench core model: result = ~core_blk, core_done 3 cycles after core_start.
- Reset, then CBC enc, iv=0: in=0 → core_blk=0, out=FF..FF, iv_out=FF..FF. Next in=FF..FF → core_blk=0, out=FF..FF.
- CBC dec, iv=0123..CDEF (128'h0123456789ABCDEF0123456789ABCDEF), in=0 → out=FF..FF ^ iv; iv_out=0. core_encrypt=0.
- CTR, CTR_BITS=32, iv=128'h00000001_00000000_00000000_FFFFFFFF, in=0 → out=~iv; iv_out=128'h00000001_00000000_00000000_00000000. Second block core_blk equals that value.
- Backpressure: out_ready=0 for 10 cycles → out_blk/out_valid stable, in_ready=0. iv_load pulsed in OUT is ignored. iv_load in IDLE → iv_out=iv_in next cycle, in_ready=0 that cycle.
- Reset asserted 1 cycle after core_start → iv_out=0, state IDLE. The following core_done produces no out_valid.
- With the real AES core, CBC-AES128 per NIST SP800-38A F.2.1: key 2b7e1516..., iv 000102..0f, pt 6bc1bee22e409f96e93d7e117393172a → ct 7649abac8119b246cee98e9b12e9197d.
